// File: rtl/viterbi_symbol_serializer_if.sv
// Frame-in / symbol-out bus of the Viterbi front-end serializer.
// slave is the serializer's view, master is the environment's view.
interface viterbi_symbol_serializer_if #(
  parameter int SYM_W    = 2,
  parameter int MAX_SYMS = 8
);
  localparam int DATA_W = SYM_W * MAX_SYMS;
  localparam int LEN_W  = $clog2(MAX_SYMS + 1);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [LEN_W-1:0]  in_len;
  logic              sym_valid;
  logic              sym_ready;
  logic [SYM_W-1:0]  sym_data;
  logic [LEN_W-1:0]  sym_idx;
  logic              sym_last;
  logic              frame_done;
  logic              err_len;
  logic              busy;

  modport master (
    output flush, in_valid, in_data, in_len, sym_ready,
    input  in_ready, sym_valid, sym_data, sym_idx, sym_last, frame_done, err_len, busy
  );

  modport slave (
    input  flush, in_valid, in_data, in_len, sym_ready,
    output in_ready, sym_valid, sym_data, sym_idx, sym_last, frame_done, err_len, busy
  );
endinterface

// File: rtl/viterbi_symbol_serializer.sv
// Serializes packed coded-symbol frames into one symbol per handshake, MSB symbol first.
// Active + pending buffers keep back-to-back frames bubble-free under back-pressure.
module viterbi_symbol_serializer #(
  parameter int SYM_W    = 2,
  parameter int MAX_SYMS = 8
) (
  input logic                         i_clk,
  input logic                         i_rst_n,
  viterbi_symbol_serializer_if.slave  bus
);
  localparam int DATA_W = SYM_W * MAX_SYMS;
  localparam int LEN_W  = $clog2(MAX_SYMS + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] act_data;
  logic [LEN_W-1:0]  act_len;
  logic [LEN_W-1:0]  act_idx;
  logic              act_last;
  logic [DATA_W-1:0] pend_data;
  logic [LEN_W-1:0]  pend_len;
  logic              pend_full;
  logic              frame_done_q;
  logic              err_len_q;

  logic in_ready_int;
  logic accept;
  logic len_ok;
  logic sym_hs;
  logic last_hs;
  logic load_in;
  logic load_pend;
  logic load_from_pend;

  assign in_ready_int   = !pend_full && !bus.flush;
  assign accept         = bus.in_valid && in_ready_int;
  assign len_ok         = (bus.in_len != '0) && (bus.in_len <= LEN_W'(MAX_SYMS));
  // flush suppresses the symbol handshake as well as the accept
  assign sym_hs         = (state == SEND) && bus.sym_ready && !bus.flush;
  assign last_hs        = sym_hs && act_last;
  assign load_in        = accept && len_ok && ((state == IDLE) || (last_hs && !pend_full));
  assign load_pend      = accept && len_ok && !load_in;
  assign load_from_pend = last_hs && pend_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (load_in) state_nxt = SEND;
        SEND:    if (last_hs && !load_from_pend && !load_in) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.sym_valid  = (state == SEND);
    bus.busy       = (state == SEND) || pend_full;
    bus.in_ready   = in_ready_int;
    bus.sym_data   = act_data[DATA_W-1 -: SYM_W];
    bus.sym_idx    = act_idx;
    bus.sym_last   = act_last;
    bus.frame_done = frame_done_q;
    bus.err_len    = err_len_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act_data     <= '0;
      act_len      <= '0;
      act_idx      <= '0;
      act_last     <= 1'b0;
      pend_data    <= '0;
      pend_len     <= '0;
      pend_full    <= 1'b0;
      frame_done_q <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      frame_done_q <= last_hs;
      err_len_q    <= accept && !len_ok;
      if (bus.flush) begin
        act_data  <= '0;
        act_idx   <= '0;
        act_last  <= 1'b0;
        pend_full <= 1'b0;
      end else begin
        if (load_in) begin
          act_data <= bus.in_data;
          act_len  <= bus.in_len;
          act_idx  <= '0;
          act_last <= (bus.in_len == LEN_W'(1));
        end else if (load_from_pend) begin
          act_data <= pend_data;
          act_len  <= pend_len;
          act_idx  <= '0;
          act_last <= (pend_len == LEN_W'(1));
        end else if (sym_hs) begin
          act_data <= act_data << SYM_W;
          act_idx  <= act_idx + LEN_W'(1);
          // next index idx+1 is last when idx+1 == len-1
          act_last <= ((act_idx + LEN_W'(2)) == act_len);
        end

        if (load_pend) begin
          pend_full <= 1'b1;
          pend_data <= bus.in_data;
          pend_len  <= bus.in_len;
        end else if (load_from_pend) begin
          pend_full <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_viterbi_symbol_serializer.sv
// Scoreboard bench for viterbi_symbol_serializer: directed scenarios then random frames,
// checked against a frame-level model (symbol queue + count of frames held).
module tb_viterbi_symbol_serializer;
  localparam int SYM_W    = 2;
  localparam int MAX_SYMS = 8;
  localparam int DATA_W   = SYM_W * MAX_SYMS;
  localparam int LEN_W    = $clog2(MAX_SYMS + 1);

  typedef struct {
    logic [SYM_W-1:0] d;
    logic [LEN_W-1:0] idx;
    logic             last;
  } sym_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  viterbi_symbol_serializer_if #(.SYM_W(SYM_W), .MAX_SYMS(MAX_SYMS)) bus ();

  viterbi_symbol_serializer #(.SYM_W(SYM_W), .MAX_SYMS(MAX_SYMS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int   errors = 0;
  int   checks = 0;
  sym_t exp_q[$];
  int   held = 0;
  logic want_done = 1'b0;
  logic want_err = 1'b0;
  int   rdy_mode = 0;
  int   stall = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endfunction

  initial begin
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_len   = '0;
    bus.sym_ready = 1'b1;
  end

  // downstream ready pattern: 0 always, 1 never, 2 random, 3 stall 3 cycles at idx 2
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: bus.sym_ready = 1'b1;
      1: bus.sym_ready = 1'b0;
      2: bus.sym_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (bus.sym_valid && bus.sym_idx == 2 && stall < 3) begin
          bus.sym_ready = 1'b0;
          stall++;
        end else begin
          bus.sym_ready = 1'b1;
        end
      end
    endcase
    if (rdy_mode != 3) stall = 0;
  end

  // monitor + reference model, sampled on the falling edge
  logic             prev_stall = 1'b0;
  logic [SYM_W-1:0] prev_d;
  logic [LEN_W-1:0] prev_idx;
  logic             prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held = 0;
      want_done = 1'b0;
      want_err = 1'b0;
      prev_stall = 1'b0;
    end else begin
      logic             hs, acc, legal, last_hs;
      logic [DATA_W-1:0] din;
      int               len;
      sym_t             e;
      chk("sym_valid", bus.sym_valid, held > 0);
      chk("busy", bus.busy, held > 0);
      chk("in_ready", bus.in_ready, (held < 2) && !bus.flush);
      chk("frame_done", bus.frame_done, want_done);
      chk("err_len", bus.err_len, want_err);
      if (prev_stall) begin
        chk("hold_data", bus.sym_data, prev_d);
        chk("hold_idx", bus.sym_idx, prev_idx);
        chk("hold_last", bus.sym_last, prev_last);
      end
      hs = bus.sym_valid && bus.sym_ready && !bus.flush;
      last_hs = 1'b0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sym", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sym_data", bus.sym_data, e.d);
          chk("sym_idx", bus.sym_idx, e.idx);
          chk("sym_last", bus.sym_last, e.last);
          last_hs = e.last;
        end
      end
      acc = bus.in_valid && bus.in_ready;
      len = int'(bus.in_len);
      legal = (len >= 1) && (len <= MAX_SYMS);
      if (acc && legal) begin
        din = bus.in_data;
        for (int k = 0; k < len; k++) begin
          e.d = din[DATA_W-1-k*SYM_W -: SYM_W];
          e.idx = LEN_W'(k);
          e.last = (k == len - 1);
          exp_q.push_back(e);
        end
      end
      want_err = acc && !legal;
      if (bus.flush) begin
        exp_q.delete();
        held = 0;
        want_done = 1'b0;
      end else begin
        want_done = last_hs;
        held = held + ((acc && legal) ? 1 : 0) - (last_hs ? 1 : 0);
      end
      prev_stall = bus.sym_valid && !bus.sym_ready && !bus.flush;
      prev_d = bus.sym_data;
      prev_idx = bus.sym_idx;
      prev_last = bus.sym_last;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l);
    int  n = 0;
    bit  done = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_len = l;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      cyc();
      n++;
      if (!done && n > 200) begin
        chk("offer_timeout", 1, 0);
        done = 1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (held != 0 && n < 300) begin
      cyc();
      n++;
    end
    chk("drain_timeout", n < 300, 1);
    cyc();
  endtask

  int t2_want[8] = '{3, 2, 1, 0, 0, 1, 2, 3};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();

    // single frame at full rate, exact symbol sequence and completion timing
    rdy_mode = 0;
    offer(16'hE41B, 4'd8);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t2_sym", bus.sym_data, t2_want[k]);
      chk("t2_last", bus.sym_last, k == 7);
    end
    @(negedge clk);
    chk("t2_done", bus.frame_done, 1);
    cyc();
    wait_idle();

    // back-pressure at idx 2
    rdy_mode = 3;
    offer(16'hE41B, 4'd8);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(bus.sym_valid && !bus.sym_ready) && n < 50);
      chk("t3_stall_seen", n < 50, 1);
      for (int k = 0; k < 3; k++) begin
        chk("t3_data", bus.sym_data, 1);
        chk("t3_idx", bus.sym_idx, 2);
        @(negedge clk);
      end
    end
    cyc();
    wait_idle();
    rdy_mode = 0;

    // async reset mid-frame
    offer(16'hE41B, 4'd8);
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_sym_valid", bus.sym_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_err_len", bus.err_len, 0);
    chk("rst_busy", bus.busy, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // back-to-back frames
    offer(16'hFFFF, 4'd3);
    offer(16'h0000, 4'd8);
    wait_idle();

    // illegal lengths
    offer(16'h1234, 4'd0);
    offer(16'h5678, 4'd9);
    wait_idle();

    // flush with pending frame and an offer outstanding
    offer(16'hA5C3, 4'd8);
    offer(16'h3C5A, 4'd8);
    bus.in_valid = 1'b1;
    bus.in_data = 16'h9999;
    bus.in_len = 4'd5;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(bus.sym_valid && bus.sym_idx == 3) && n < 50);
      chk("t6_idx3_seen", n < 50, 1);
    end
    cyc();
    chk("t6_idx4", bus.sym_idx, 4);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("t6_valid", bus.sym_valid, 0);
    chk("t6_busy", bus.busy, 0);
    cyc();

    // random frames, random back-pressure, occasional flush
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      logic [LEN_W-1:0] l;
      if ($urandom_range(0, 19) == 0)
        l = ($urandom_range(0, 1) == 0) ? LEN_W'(0) : LEN_W'($urandom_range(9, 15));
      else
        l = LEN_W'($urandom_range(1, 8));
      if ($urandom_range(0, 29) == 0) begin
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
      end
      repeat ($urandom_range(0, 2)) cyc();
      offer(DATA_W'($urandom), l);
    end
    rdy_mode = 0;
    wait_idle();
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
